// File: rtl/simd_issue_exec.sv
// Two-stage SIMD execute pipeline (E, W) feeding a 4 x 8-bit vector register file.
// Operands are forwarded from E and W so dependent instructions issue back to back.
module simd_issue_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [11:0] in_instr,
   output logic        in_ready,
   output logic [2:0]  addr_a,
   output logic [2:0]  addr_b,
   input  logic [31:0] vec_a,
   input  logic [31:0] vec_b,
   output logic        write_enable,
   output logic [2:0]  write_addr,
   output logic [31:0] write_data,
   output logic        busy
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_ADDS = 3'd2,
      OP_MUL  = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5,
      OP_XOR  = 3'd6,
      OP_MOV  = 3'd7
   } op_e;

   typedef enum logic {
      MUL_P0 = 1'b0,
      MUL_P1 = 1'b1
   } mul_ph_e;

   logic        e_valid_q, e_valid_d;
   op_e         e_op_q,    e_op_d;
   logic [2:0]  e_dest_q,  e_dest_d;
   logic [31:0] e_a_q,     e_a_d;
   logic [31:0] e_b_q,     e_b_d;
   logic        w_valid_q, w_valid_d;
   logic [2:0]  w_dest_q,  w_dest_d;
   logic [31:0] w_data_q,  w_data_d;
   mul_ph_e     mul_ph_q,  mul_ph_d;

   logic [31:0] alu_out;
   logic [31:0] opnd_a, opnd_b;
   logic        mul_hold;
   logic        accept;

   assign addr_a       = in_instr[5:3];
   assign addr_b       = in_instr[2:0];
   assign write_enable = w_valid_q;
   assign write_addr   = w_dest_q;
   assign write_data   = w_data_q;
   assign busy         = e_valid_q | w_valid_q;

   // MUL occupies E for two cycles; the first cycle blocks issue.
   assign mul_hold = e_valid_q & (e_op_q == OP_MUL) & (mul_ph_q == MUL_P0);
   assign in_ready = rst & ~mul_hold;
   assign accept   = in_valid & in_ready;

   always_comb begin
      logic [7:0]  la, lb;
      logic [8:0]  sum;
      logic [15:0] prod;
      alu_out = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         la   = e_a_q[8*i +: 8];
         lb   = e_b_q[8*i +: 8];
         sum  = {1'b0, la} + {1'b0, lb};
         prod = {8'd0, la} * {8'd0, lb};
         case (e_op_q)
            OP_ADD:  alu_out[8*i +: 8] = sum[7:0];
            OP_SUB:  alu_out[8*i +: 8] = la - lb;
            OP_ADDS: alu_out[8*i +: 8] = sum[8] ? 8'hFF : sum[7:0];
            OP_MUL:  alu_out[8*i +: 8] = prod[7:0];
            OP_AND:  alu_out[8*i +: 8] = la & lb;
            OP_OR:   alu_out[8*i +: 8] = la | lb;
            OP_XOR:  alu_out[8*i +: 8] = la ^ lb;
            default: alu_out[8*i +: 8] = la;
         endcase
      end
   end

   // E is the younger value, so it outranks W; both outrank the file.
   always_comb begin
      if (e_valid_q && (e_dest_q == addr_a))      opnd_a = alu_out;
      else if (w_valid_q && (w_dest_q == addr_a)) opnd_a = w_data_q;
      else                                        opnd_a = vec_a;
      if (e_valid_q && (e_dest_q == addr_b))      opnd_b = alu_out;
      else if (w_valid_q && (w_dest_q == addr_b)) opnd_b = w_data_q;
      else                                        opnd_b = vec_b;
   end

   always_comb begin
      e_valid_d = e_valid_q;
      e_op_d    = e_op_q;
      e_dest_d  = e_dest_q;
      e_a_d     = e_a_q;
      e_b_d     = e_b_q;
      w_valid_d = w_valid_q;
      w_dest_d  = w_dest_q;
      w_data_d  = w_data_q;
      mul_ph_d  = mul_ph_q;
      if (mul_hold) begin
         w_valid_d = 1'b0;
         mul_ph_d  = MUL_P1;
      end else begin
         mul_ph_d  = MUL_P0;
         w_valid_d = e_valid_q;
         if (e_valid_q) begin
            w_dest_d = e_dest_q;
            w_data_d = alu_out;
         end
         e_valid_d = accept;
         if (accept) begin
            e_op_d   = op_e'(in_instr[11:9]);
            e_dest_d = in_instr[8:6];
            e_a_d    = opnd_a;
            e_b_d    = opnd_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_valid_q <= 1'b0;
         e_op_q    <= OP_ADD;
         e_dest_q  <= '0;
         e_a_q     <= '0;
         e_b_q     <= '0;
         w_valid_q <= 1'b0;
         w_dest_q  <= '0;
         w_data_q  <= '0;
         mul_ph_q  <= MUL_P0;
      end else begin
         e_valid_q <= e_valid_d;
         e_op_q    <= e_op_d;
         e_dest_q  <= e_dest_d;
         e_a_q     <= e_a_d;
         e_b_q     <= e_b_d;
         w_valid_q <= w_valid_d;
         w_dest_q  <= w_dest_d;
         w_data_q  <= w_data_d;
         mul_ph_q  <= mul_ph_d;
      end
   end

endmodule
